ll_head_table_ctrl: RTL

Initiator side of the linked-list command/result protocol. Owns the head-pointer table (one {ptr, val} entry per bucket) and accepts user requests of the form {key, opcode, bucket}. For each request it reads the bucket's head entry, issues a command with head_ptr/head_ptr_val to the linked-list engine, and applies the engine's head-table write-back to that bucket. It then returns the result upstream. Exactly one command is outstanding at a time, so there is no bucket hazard.

---
 rtl/linked_list.sv | 29 ++
 rtl/ll_head_table_ram.sv | 31 +++
 rtl/ll_head_table_ctrl.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/linked_list.sv
// Shared linked-list protocol definitions: widths, opcode/result encodings,
// the head-table entry layout and the head-table controller state encoding.
package linked_list;

    localparam int LL_KEY_WIDTH      = 32;
    localparam int LL_HEAD_PTR_WIDTH = 10;

    localparam logic [1:0] LL_OP_INSERT  = 2'd0;
    localparam logic [1:0] LL_OP_DELETE  = 2'd1;
    localparam logic [1:0] LL_OP_DEQ     = 2'd2;
    localparam logic [1:0] LL_OP_ILLEGAL = 2'd3;

    localparam logic [2:0] LL_RESCODE_ILLEGAL = 3'd7;

    typedef struct packed {
        logic [LL_HEAD_PTR_WIDTH-1:0] ptr;
        logic                         val;
    } ll_head_entry_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_HEAD,
        ST_ISSUE,
        ST_WAIT_RES,
        ST_RESP,
        ST_CLEAR
    } ll_ht_state_e;

endpackage

// File: rtl/ll_head_table_ram.sv
// Simple dual-port head-table RAM: one write port, one read port whose data
// appears RAM_LATENCY cycles after the address through a register pipeline.
module ll_head_table_ram #(
    parameter int DATA_WIDTH  = 11,
    parameter int ADDR_WIDTH  = 8,
    parameter int RAM_LATENCY = 2
) (
    input  logic                  clk_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i
);

    logic [DATA_WIDTH-1:0] mem_q     [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] rd_pipe_q [RAM_LATENCY];

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        rd_pipe_q[0] <= mem_q[rd_addr_i];
        for (int i = 1; i < RAM_LATENCY; i++) begin
            rd_pipe_q[i] <= rd_pipe_q[i-1];
        end
    end

    assign rd_data_o = rd_pipe_q[RAM_LATENCY-1];

endmodule

// File: rtl/ll_head_table_ctrl.sv
// Linked-list initiator: owns the per-bucket head table, issues one engine command
// at a time and applies head write-backs. Optional counters under LL_HT_STATS_EN.
module ll_head_table_ctrl
    import linked_list::*;
#(
    parameter int KEY_WIDTH      = 32,
    parameter int HEAD_PTR_WIDTH = 10,
    parameter int BUCKET_WIDTH   = 8,
    parameter int RAM_LATENCY    = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      req_valid_i,
    output logic                      req_ready_o,
    input  logic [KEY_WIDTH-1:0]      req_key_i,
    input  logic [1:0]                req_opcode_i,
    input  logic [BUCKET_WIDTH-1:0]   req_bucket_i,
    output logic                      ll_cmd_valid_o,
    input  logic                      ll_cmd_ready_i,
    output logic [KEY_WIDTH-1:0]      ll_cmd_key_o,
    output logic [1:0]                ll_cmd_opcode_o,
    output logic [HEAD_PTR_WIDTH-1:0] ll_cmd_head_ptr_o,
    output logic                      ll_cmd_head_ptr_val_o,
    input  logic                      ll_res_valid_i,
    output logic                      ll_res_ready_o,
    input  logic [KEY_WIDTH-1:0]      ll_res_key_i,
    input  logic [1:0]                ll_res_opcode_i,
    input  logic [2:0]                ll_res_rescode_i,
    input  logic [2:0]                ll_res_chain_state_i,
    input  logic [HEAD_PTR_WIDTH-1:0] ht_wr_data_ptr_i,
    input  logic                      ht_wr_data_ptr_val_i,
    input  logic                      ht_wr_en_i,
    output logic                      rsp_valid_o,
    input  logic                      rsp_ready_i,
    output logic [KEY_WIDTH-1:0]      rsp_key_o,
    output logic [1:0]                rsp_opcode_o,
    output logic [2:0]                rsp_rescode_o,
    output logic [2:0]                rsp_chain_state_o,
    input  logic                      clear_run_i,
    output logic                      clear_done_o
`ifdef LL_HT_STATS_EN
    ,
    output logic [31:0]               stat_cmd_cnt_o,
    output logic [15:0]               stat_stray_wr_cnt_o
`endif
);

    localparam int ENTRY_W = HEAD_PTR_WIDTH + 1;
    localparam int LATW    = (RAM_LATENCY > 1) ? $clog2(RAM_LATENCY) : 1;
    localparam logic [LATW-1:0]         LAT_LAST    = LATW'(RAM_LATENCY - 1);
    localparam logic [BUCKET_WIDTH-1:0] ADDR_LAST   = '1;
    localparam logic [BUCKET_WIDTH-1:0] ADDR_PENULT = ADDR_LAST - 1'b1;

    ll_ht_state_e              state_q;
    logic [BUCKET_WIDTH-1:0]   bucket_q;
    logic [BUCKET_WIDTH-1:0]   clr_addr_q;
    logic [LATW-1:0]           lat_cnt_q;
    logic                      clear_pend_q;

    logic                      req_ready_q;
    logic                      ll_cmd_valid_q;
    logic [KEY_WIDTH-1:0]      ll_cmd_key_q;
    logic [1:0]                ll_cmd_opcode_q;
    logic [HEAD_PTR_WIDTH-1:0] ll_cmd_head_ptr_q;
    logic                      ll_cmd_head_ptr_val_q;
    logic                      ll_res_ready_q;
    logic                      rsp_valid_q;
    logic [KEY_WIDTH-1:0]      rsp_key_q;
    logic [1:0]                rsp_opcode_q;
    logic [2:0]                rsp_rescode_q;
    logic [2:0]                rsp_chain_state_q;
    logic                      clear_done_q;

    logic                      req_hs;
    logic                      wb_window;
    logic [BUCKET_WIDTH-1:0]   ram_rd_addr;
    logic [ENTRY_W-1:0]        ram_rd_data;
    logic                      ram_wr_en;
    logic [BUCKET_WIDTH-1:0]   ram_wr_addr;
    logic [ENTRY_W-1:0]        ram_wr_data;

    assign req_hs    = (state_q == ST_IDLE) && req_valid_i && req_ready_q;
    assign wb_window = (state_q == ST_ISSUE) || (state_q == ST_WAIT_RES);

    // The read address follows the live request in IDLE so the accept cycle starts the read.
    always_comb begin
        ram_rd_addr = (state_q == ST_IDLE) ? req_bucket_i : bucket_q;
        ram_wr_en   = 1'b0;
        ram_wr_addr = bucket_q;
        ram_wr_data = {ht_wr_data_ptr_i, ht_wr_data_ptr_val_i};
        if (state_q == ST_CLEAR) begin
            ram_wr_en   = 1'b1;
            ram_wr_addr = clr_addr_q;
            ram_wr_data = '0;
        end else if (wb_window && ht_wr_en_i) begin
            ram_wr_en   = 1'b1;
        end
    end

    ll_head_table_ram #(
        .DATA_WIDTH  (ENTRY_W),
        .ADDR_WIDTH  (BUCKET_WIDTH),
        .RAM_LATENCY (RAM_LATENCY)
    ) u_ram (
        .clk_i     (clk_i),
        .rd_addr_i (ram_rd_addr),
        .rd_data_o (ram_rd_data),
        .wr_en_i   (ram_wr_en),
        .wr_addr_i (ram_wr_addr),
        .wr_data_i (ram_wr_data)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q               <= ST_IDLE;
            bucket_q              <= '0;
            clr_addr_q            <= '0;
            lat_cnt_q             <= '0;
            clear_pend_q          <= 1'b0;
            req_ready_q           <= 1'b1;
            ll_cmd_valid_q        <= 1'b0;
            ll_cmd_key_q          <= '0;
            ll_cmd_opcode_q       <= '0;
            ll_cmd_head_ptr_q     <= '0;
            ll_cmd_head_ptr_val_q <= 1'b0;
            ll_res_ready_q        <= 1'b0;
            rsp_valid_q           <= 1'b0;
            rsp_key_q             <= '0;
            rsp_opcode_q          <= '0;
            rsp_rescode_q         <= '0;
            rsp_chain_state_q     <= '0;
            clear_done_q          <= 1'b0;
        end else begin
            clear_done_q <= 1'b0;
            if (clear_run_i) begin
                clear_pend_q <= 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (req_hs) begin
                        req_ready_q <= 1'b0;
                        if (req_opcode_i == LL_OP_ILLEGAL) begin
                            rsp_valid_q       <= 1'b1;
                            rsp_key_q         <= req_key_i;
                            rsp_opcode_q      <= req_opcode_i;
                            rsp_rescode_q     <= LL_RESCODE_ILLEGAL;
                            rsp_chain_state_q <= '0;
                            state_q           <= ST_RESP;
                        end else begin
                            bucket_q        <= req_bucket_i;
                            lat_cnt_q       <= '0;
                            ll_cmd_key_q    <= req_key_i;
                            ll_cmd_opcode_q <= req_opcode_i;
                            state_q         <= ST_RD_HEAD;
                        end
                    end else if (clear_pend_q || clear_run_i) begin
                        clear_pend_q <= 1'b0;
                        clr_addr_q   <= '0;
                        req_ready_q  <= 1'b0;
                        state_q      <= ST_CLEAR;
                    end
                end
                ST_RD_HEAD: begin
                    if (lat_cnt_q == LAT_LAST) begin
                        ll_cmd_head_ptr_q     <= ram_rd_data[ENTRY_W-1:1];
                        ll_cmd_head_ptr_val_q <= ram_rd_data[0];
                        ll_cmd_valid_q        <= 1'b1;
                        state_q               <= ST_ISSUE;
                    end else begin
                        lat_cnt_q <= lat_cnt_q + 1'b1;
                    end
                end
                ST_ISSUE: begin
                    if (ll_cmd_ready_i) begin
                        ll_cmd_valid_q <= 1'b0;
                        ll_res_ready_q <= 1'b1;
                        state_q        <= ST_WAIT_RES;
                    end
                end
                ST_WAIT_RES: begin
                    if (ll_res_valid_i) begin
                        ll_res_ready_q    <= 1'b0;
                        rsp_valid_q       <= 1'b1;
                        rsp_key_q         <= ll_res_key_i;
                        rsp_opcode_q      <= ll_res_opcode_i;
                        rsp_rescode_q     <= ll_res_rescode_i;
                        rsp_chain_state_q <= ll_res_chain_state_i;
                        state_q           <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= !(clear_pend_q || clear_run_i);
                        state_q     <= ST_IDLE;
                    end
                end
                ST_CLEAR: begin
                    // A clear request on the final address queues a fresh sweep instead of restarting.
                    if (clr_addr_q == ADDR_LAST) begin
                        clear_pend_q <= clear_run_i;
                        req_ready_q  <= !clear_run_i;
                        state_q      <= ST_IDLE;
                    end else if (clear_run_i) begin
                        clear_pend_q <= 1'b0;
                        clr_addr_q   <= '0;
                    end else begin
                        clr_addr_q <= clr_addr_q + 1'b1;
                        if (clr_addr_q == ADDR_PENULT) begin
                            clear_done_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready_o           = req_ready_q;
    assign ll_cmd_valid_o        = ll_cmd_valid_q;
    assign ll_cmd_key_o          = ll_cmd_key_q;
    assign ll_cmd_opcode_o       = ll_cmd_opcode_q;
    assign ll_cmd_head_ptr_o     = ll_cmd_head_ptr_q;
    assign ll_cmd_head_ptr_val_o = ll_cmd_head_ptr_val_q;
    assign ll_res_ready_o        = ll_res_ready_q;
    assign rsp_valid_o           = rsp_valid_q;
    assign rsp_key_o             = rsp_key_q;
    assign rsp_opcode_o          = rsp_opcode_q;
    assign rsp_rescode_o         = rsp_rescode_q;
    assign rsp_chain_state_o     = rsp_chain_state_q;
    assign clear_done_o          = clear_done_q;

`ifdef LL_HT_STATS_EN
    logic [31:0] stat_cmd_cnt_q;
    logic [15:0] stat_stray_wr_cnt_q;
    logic        clear_sweep_start;
    logic        stray_wr;

    assign clear_sweep_start = ((state_q == ST_IDLE) && !req_hs && (clear_pend_q || clear_run_i))
                             || ((state_q == ST_CLEAR) && clear_run_i && (clr_addr_q != ADDR_LAST));
    assign stray_wr          = ht_wr_en_i && !wb_window;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stat_cmd_cnt_q      <= '0;
            stat_stray_wr_cnt_q <= '0;
        end else if (clear_sweep_start) begin
            stat_cmd_cnt_q      <= '0;
            stat_stray_wr_cnt_q <= '0;
        end else begin
            if (ll_cmd_valid_q && ll_cmd_ready_i) begin
                stat_cmd_cnt_q <= stat_cmd_cnt_q + 32'd1;
            end
            if (stray_wr && (stat_stray_wr_cnt_q != 16'hFFFF)) begin
                stat_stray_wr_cnt_q <= stat_stray_wr_cnt_q + 16'd1;
            end
        end
    end

    assign stat_cmd_cnt_o      = stat_cmd_cnt_q;
    assign stat_stray_wr_cnt_o = stat_stray_wr_cnt_q;
`endif

endmodule
